matrix_op_seq: RTL and testbench

MATRIX_OP_SEQ -- requirements
Module: matrix_op_seq

---
 rtl/matrix_op_seq.sv | 186 ++++++++++++++++++
 tb/tb_matrix_op_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_seq.sv
// rtl/matrix_op_seq.sv - row-wise packed matrix add/sub sequencer
//
// Purpose: walks ROWS rows of the A/B source banks, feeds each row pair to an
// external registered ALU and writes the result row to the result bank.
// Each row takes four cycles: FETCH, ISSUE, EXEC, WRITE.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op         operation request (taken in IDLE), 0 = A-B, 1 = A+B
//   busy, done        operation in progress / one-cycle completion pulse
//   ovf_flag, halted  sticky ALU overflow / early stop on overflow
//   rd_addr, rd_a/b   source bank read port (data one cycle after address)
//   alu_m1/m2, alu_op registered ALU operands and operation
//   alu_out, alu_ovf  ALU result and overflow, one cycle after operands
//   wr_en/addr/data   result bank write port
//
// Build option: define OVF_HALT_EN to end the operation at the first row
// whose ALU result overflows; otherwise halted is tied low.

module matrix_op_seq #(
  parameter int ROWS  = 5,
  parameter int LANES = 5,
  parameter int EW    = 8,
  localparam int RW = LANES * EW,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  output logic          busy,
  output logic          done,
  output logic          ovf_flag,
  output logic          halted,
  output logic [AW-1:0] rd_addr,
  input  logic [RW-1:0] rd_a,
  input  logic [RW-1:0] rd_b,
  output logic [RW-1:0] alu_m1,
  output logic [RW-1:0] alu_m2,
  output logic          alu_op,
  input  logic [RW-1:0] alu_out,
  input  logic          alu_ovf,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [RW-1:0] wr_data
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic          op_q, op_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [RW-1:0] m1_q, m1_d;
  logic [RW-1:0] m2_q, m2_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_en_q, wr_en_d;
  logic          last_row;
  logic          stop_early;

  assign last_row = (row_q == AW'(ROWS - 1));

`ifdef OVF_HALT_EN
  logic halted_q, halted_d;
  assign stop_early = alu_ovf;
  assign halted     = halted_q;
`else
  assign stop_early = 1'b0;
  assign halted     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    op_d      = op_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
`ifdef OVF_HALT_EN
    halted_d  = halted_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          row_d     = '0;
          ovf_d     = 1'b0;
          busy_d    = 1'b1;
          // Address is presented during FETCH so the bank samples it on the
          // edge leaving FETCH and the row is readable during ISSUE.
          rd_addr_d = '0;
`ifdef OVF_HALT_EN
          halted_d  = 1'b0;
`endif
          state_d   = FETCH;
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        m1_d    = rd_a;
        m2_d    = rd_b;
        state_d = EXEC;
      end
      EXEC: begin
        // Write strobe and address are registered so they line up with the
        // ALU result that becomes valid during WRITE.
        wr_en_d   = 1'b1;
        wr_addr_d = row_q;
        state_d   = WRITE;
      end
      WRITE: begin
        ovf_d = ovf_q | alu_ovf;
        if (last_row || stop_early) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef OVF_HALT_EN
          halted_d = alu_ovf;
`endif
          state_d = DONE;
        end else begin
          row_d     = row_q + AW'(1);
          rd_addr_d = row_q + AW'(1);
          state_d   = FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      op_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      m1_q      <= '0;
      m2_q      <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
`ifdef OVF_HALT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
`ifdef OVF_HALT_EN
      halted_q  <= halted_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf_flag = ovf_q;
  assign rd_addr  = rd_addr_q;
  assign alu_m1   = m1_q;
  assign alu_m2   = m2_q;
  assign alu_op   = op_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  // ALU output is already registered; the write port takes it straight
  // through during WRITE.
  assign wr_data  = alu_out;

endmodule

// File: tb/tb_matrix_op_seq.sv
// tb/tb_matrix_op_seq.sv - scoreboard bench for matrix_op_seq
module tb_matrix_op_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        busy, done, ovf_flag, halted;
  logic [2:0]  rd_addr, wr_addr;
  logic [39:0] rd_a, rd_b, alu_m1, alu_m2, alu_out, wr_data;
  logic        alu_op, alu_ovf, wr_en;

  matrix_op_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .busy(busy), .done(done), .ovf_flag(ovf_flag), .halted(halted),
    .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
    .alu_m1(alu_m1), .alu_m2(alu_m2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int fails = 0;
  int wr_count = 0;
  int start_cyc = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [39:0] data;
  } exp_t;
  exp_t sb[$];

  logic [39:0] a_mem[5], b_mem[5];
  logic [39:0] exp_sub[5], exp_add[5], exp_ovf[5];

  function automatic logic [39:0] pk(input int e0, e1, e2, e3, e4);
    return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Source banks: synchronous read.
  always @(posedge clk) begin
    rd_a <= a_mem[rd_addr];
    rd_b <= b_mem[rd_addr];
  end

  // External ALU: registered, per-lane signed 8-bit add/sub.
  function automatic logic [40:0] alu_calc(input logic [39:0] m1, m2, input logic o);
    logic [39:0] r;
    logic        v;
    int          x;
    v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = o ? int'($signed(m1[i*8 +: 8])) + int'($signed(m2[i*8 +: 8]))
            : int'($signed(m1[i*8 +: 8])) - int'($signed(m2[i*8 +: 8]));
      if (x > 127 || x < -128) v = 1'b1;
      r[i*8 +: 8] = 8'(x);
    end
    return {v, r};
  endfunction

  always @(posedge clk) begin
    {alu_ovf, alu_out} <= alu_calc(alu_m1, alu_m2, alu_op);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      wr_count++;
      if (sb.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic push_rows(input int sel, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = 3'(i);
      e.data = (sel == 0) ? exp_sub[i] : (sel == 1) ? exp_add[i] : exp_ovf[i];
      sb.push_back(e);
    end
  endtask

  task automatic start_op(input logic o);
    @(negedge clk);
    start = 1'b1;
    op = o;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc - 1;
    check("busy_after_start", 64'(busy), 64'd1);
    check("ovf_cleared_at_start", 64'(ovf_flag), 64'd0);
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (seen) begin
      lat = cyc - start_cyc;
      check("busy_low_in_done", 64'(busy), 64'd0);
    end else begin
      tests_run++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  int lat;
  int exp_lat;
  int exp_writes;
  logic exp_halt;
  bit seen_done;
  bit found;

  initial begin
    a_mem[0] = pk(50, 40, 30, 20, 10);     b_mem[0] = pk(45, 35, 25, 15, 5);
    a_mem[1] = pk(1, 2, 3, 4, 5);          b_mem[1] = pk(1, 1, 1, 1, 1);
    a_mem[2] = pk(50, -40, 30, -20, 10);   b_mem[2] = pk(-45, 35, -25, 15, -5);
    a_mem[3] = pk(0, 0, 0, 0, 0);          b_mem[3] = pk(10, -10, 127, -127, 1);
    a_mem[4] = pk(-1, -2, -3, -4, -5);     b_mem[4] = pk(-1, -2, -3, -4, -5);

    exp_sub[0] = pk(5, 5, 5, 5, 5);
    exp_sub[1] = pk(0, 1, 2, 3, 4);
    exp_sub[2] = pk(95, -75, 55, -35, 15);
    exp_sub[3] = pk(-10, 10, -127, 127, -1);
    exp_sub[4] = pk(0, 0, 0, 0, 0);

    exp_add[0] = pk(95, 75, 55, 35, 15);
    exp_add[1] = pk(2, 3, 4, 5, 6);
    exp_add[2] = pk(5, -5, 5, -5, 5);
    exp_add[3] = pk(10, -10, 127, -127, 1);
    exp_add[4] = pk(-2, -4, -6, -8, -10);

    exp_ovf = exp_sub;
    exp_ovf[1] = pk(-106, -127, 126, 126, 70);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_ovf", 64'(ovf_flag), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_m1", 64'(alu_m1), 64'd0);
    check("rst_m2", 64'(alu_m2), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;

    // Subtract, no overflow
    wr_count = 0;
    push_rows(0, 5);
    start_op(1'b0);
    wait_done(lat);
    check("sub_latency", 64'(lat), 64'd21);
    check("sub_ovf", 64'(ovf_flag), 64'd0);
    check("sub_halted", 64'(halted), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("sub_writes", 64'(wr_count), 64'd5);
    check("sub_sb_empty", 64'(sb.size()), 64'd0);

    // Add, with op toggled while busy and start held during DONE
    wr_count = 0;
    push_rows(1, 5);
    start_op(1'b1);
    repeat (3) @(negedge clk);
    op = 1'b0;
    wait_done(lat);
    check("add_latency", 64'(lat), 64'd21);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    check("start_in_done_still_idle", 64'(busy), 64'd0);
    check("alu_op_held", 64'(alu_op), 64'd1);
    check("add_writes", 64'(wr_count), 64'd5);

    // Overflow on row 1, plus a start pulse while busy
    a_mem[1] = pk(50, -128, 127, -100, 100);
    b_mem[1] = pk(-100, -1, 1, 30, 30);
`ifdef OVF_HALT_EN
    exp_lat = 9; exp_writes = 2; exp_halt = 1'b1;
`else
    exp_lat = 21; exp_writes = 5; exp_halt = 1'b0;
`endif
    wr_count = 0;
    push_rows(2, exp_writes);
    start_op(1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ovf_latency", 64'(lat), 64'(exp_lat));
    check("ovf_flag_set", 64'(ovf_flag), 64'd1);
    check("ovf_halted", 64'(halted), 64'(exp_halt));
    check("ovf_writes", 64'(wr_count), 64'(exp_writes));

    // Restart one cycle after done: flag holds in IDLE, clears on start
    a_mem[1] = pk(1, 2, 3, 4, 5);
    b_mem[1] = pk(1, 1, 1, 1, 1);
    wr_count = 0;
    push_rows(0, 5);
    @(negedge clk);
    check("ovf_flag_held_idle", 64'(ovf_flag), 64'd1);
    start = 1'b1;
    op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc - 1;
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_ovf_cleared", 64'(ovf_flag), 64'd0);
    check("restart_halted_cleared", 64'(halted), 64'd0);
    wait_done(lat);
    check("restart_latency", 64'(lat), 64'd21);
    check("restart_writes", 64'(wr_count), 64'd5);

    // Reset during EXEC of row 3
    wr_count = 0;
    push_rows(0, 3);
    start_op(1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 3'd2) found = 1'b1;
    end
    check("row2_write_seen", 64'(found), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_rd_addr", 64'(rd_addr), 64'd0);
    check("abort_m1", 64'(alu_m1), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_writes", 64'(wr_count), 64'd3);
    check("abort_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
